// File: rtl/esc_quad_pwm.sv
// Quad ESC PWM generator: one shared frame counter, four per-frame shadowed speed channels.
// Optional arming sequence (base pulses for ARM_FRAMES frames) enabled by macro ESC_ARMING_EN.
module esc_quad_pwm #(
  parameter int unsigned PERIOD_CNT = 125000,
  parameter int unsigned BASE_PULSE = 50000,
  parameter int unsigned SPEED_MULT = 3,
  parameter int unsigned ARM_FRAMES = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  input  logic        kill,
  output logic        frnt_pwm,
  output logic        bck_pwm,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        frm_strt,
  output logic        armed
);

  localparam int unsigned CW        = $clog2(PERIOD_CNT);
  localparam int unsigned MAX_PULSE = BASE_PULSE + 2047 * SPEED_MULT;
  localparam logic [CW-1:0] LAST    = CW'(PERIOD_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          latch;
  logic          kill_pend_q, kill_pend_d, kill_eff;
  logic [10:0]   spd      [4];
  logic [10:0]   shadow_q [4];
  logic [10:0]   shadow_d [4];
  logic [16:0]   pulse    [4];
  logic [3:0]    pwm_q, pwm_d;
  logic          frm_strt_q, armed_q, armed_d;
  logic          use_base;

  function automatic logic [16:0] pulse_of(input logic [10:0] s);
    logic [12:0] prod;
    prod = 13'(s) * 13'(SPEED_MULT);
    return 17'(BASE_PULSE) + 17'(prod);
  endfunction

  assign spd   = '{frnt_spd, bck_spd, lft_spd, rght_spd};
  assign latch = (cnt_q == LAST);
  assign cnt_d = latch ? '0 : cnt_q + 1'b1;

  // A kill pulse seen anywhere in the frame is held until the next latch edge.
  assign kill_eff    = kill | kill_pend_q;
  assign kill_pend_d = latch ? 1'b0 : kill_eff;

  // Registered pwm is decided from the next counter value so it rises on the latch edge.
  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      shadow_d[i] = shadow_q[i];
      if (latch) shadow_d[i] = kill_eff ? '0 : spd[i];
      pulse[i] = use_base ? 17'(BASE_PULSE) : pulse_of(shadow_d[i]);
      pwm_d[i] = (32'(cnt_d) < 32'(pulse[i]));
    end
  end

`ifdef ESC_ARMING_EN
  localparam int unsigned AW = $clog2(ARM_FRAMES + 1);

  typedef enum logic {ARM, RUN} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;

  // The kill latch edge already begins the first re-arming frame, hence count restarts at 1.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (latch) begin
      case (state_q)
        ARM: begin
          if (arm_cnt_q == AW'(ARM_FRAMES)) begin
            state_d   = RUN;
            arm_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (kill_eff) begin
            state_d   = ARM;
            arm_cnt_d = AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARM;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign use_base = (state_d == ARM);
  assign armed_d  = (state_d == RUN);
`else
  assign use_base = 1'b0;
  assign armed_d  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= LAST;
      kill_pend_q <= 1'b0;
      shadow_q    <= '{default: '0};
      pwm_q       <= '0;
      frm_strt_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      kill_pend_q <= kill_pend_d;
      shadow_q    <= shadow_d;
      pwm_q       <= pwm_d;
      frm_strt_q  <= (cnt_d == '0);
      armed_q     <= armed_d;
    end
  end

  assign frnt_pwm = pwm_q[0];
  assign bck_pwm  = pwm_q[1];
  assign lft_pwm  = pwm_q[2];
  assign rght_pwm = pwm_q[3];
  assign frm_strt = frm_strt_q;
  assign armed    = armed_q;

  param_ok: assert property (@(posedge clk) (MAX_PULSE < PERIOD_CNT) && (ARM_FRAMES > 0));

endmodule

// File: tb/tb_esc_quad_pwm.sv
// Self-checking bench for esc_quad_pwm: per-frame high time, strobe placement, armed level
// and async reset, against a frame-level model driven by directed and random stimulus.
module tb_esc_quad_pwm;

  localparam int unsigned P    = 6200;
  localparam int unsigned BASE = 40;
  localparam int unsigned MULT = 3;
  localparam int unsigned ARMF = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kill = 1'b0;
  logic [10:0] spd [4];
  logic [3:0]  pwm;
  logic        frm_strt, armed;

  always #5 clk = ~clk;

  esc_quad_pwm #(
    .PERIOD_CNT(P),
    .BASE_PULSE(BASE),
    .SPEED_MULT(MULT),
    .ARM_FRAMES(ARMF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .frnt_spd (spd[0]),
    .bck_spd  (spd[1]),
    .lft_spd  (spd[2]),
    .rght_spd (spd[3]),
    .kill     (kill),
    .frnt_pwm (pwm[0]),
    .bck_pwm  (pwm[1]),
    .lft_pwm  (pwm[2]),
    .rght_pwm (pwm[3]),
    .frm_strt (frm_strt),
    .armed    (armed)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Frame-level model state
  int unsigned k;          // clock edges since reset release
  int          fi;         // index of the frame currently running
  int          arm_start;
  bit          in_arm, kill_seen, exp_armed;
  int unsigned exp_hi [4];

  // Per-frame measurements
  int unsigned hi [4];
  bit          bad_shape [4];
  bit          prev [4];
  int unsigned strt_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic latch_model();
    bit k_eff;
    k_eff     = kill || kill_seen;
    kill_seen = 1'b0;
    fi++;
`ifdef ESC_ARMING_EN
    if (in_arm && (fi - arm_start) >= int'(ARMF)) in_arm = 1'b0;
    else if (!in_arm && k_eff) begin
      in_arm    = 1'b1;
      arm_start = fi;
    end
`endif
    for (int c = 0; c < 4; c++)
      exp_hi[c] = in_arm ? BASE : BASE + MULT * (k_eff ? 0 : int'(spd[c]));
    exp_armed = !in_arm;
  endtask

  task automatic observe(input int unsigned pos);
    if (pos == 0) begin
      strt_n = 0;
      for (int c = 0; c < 4; c++) begin
        hi[c] = 0;
        bad_shape[c] = 1'b0;
      end
    end
    if (frm_strt === 1'b1) strt_n += (pos == 0) ? 1 : 100;
    for (int c = 0; c < 4; c++) begin
      if (pwm[c] === 1'b1) begin
        hi[c]++;
        if (pos != 0 && !prev[c]) bad_shape[c] = 1'b1;
      end else if (pos == 0) begin
        bad_shape[c] = 1'b1;
      end
      prev[c] = (pwm[c] === 1'b1);
    end
    if (pos == P - 1) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("high_time_ch%0d_f%0d", c, fi), hi[c], exp_hi[c]);
        check($sformatf("pulse_shape_ch%0d_f%0d", c, fi), 32'(bad_shape[c]), 32'd0);
      end
      check($sformatf("frm_strt_f%0d", fi), strt_n, 32'd1);
      check($sformatf("armed_f%0d", fi), 32'(armed), 32'(exp_armed));
    end
  endtask

  task automatic cycle();
    if (k % P == 0) latch_model();
    else if (kill) kill_seen = 1'b1;
    @(posedge clk);
    @(negedge clk);
    observe(k % P);
    k++;
  endtask

  task automatic finish_frame();
    do cycle(); while (k % P != 0);
  endtask

  task automatic run_to(input int unsigned pos);
    while (k % P != pos) cycle();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    k         = 0;
    fi        = -1;
    kill_seen = 1'b0;
    arm_start = 0;
`ifdef ESC_ARMING_EN
    in_arm = 1'b1;
`else
    in_arm = 1'b0;
`endif
  endtask

  task automatic set_spd(input logic [10:0] f, input logic [10:0] b,
                         input logic [10:0] l, input logic [10:0] r);
    spd[0] = f; spd[1] = b; spd[2] = l; spd[3] = r;
  endtask

  task automatic random_spd();
    for (int c = 0; c < 4; c++) spd[c] = 11'($urandom_range(0, 2047));
  endtask

  initial begin
    set_spd(11'h000, 11'h000, 11'h000, 11'h000);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_frm_strt", 32'(frm_strt), 32'd0);
    check("reset_armed", 32'(armed), 32'd0);
    release_reset();

    // All speeds zero
    finish_frame();

    // Extreme / mixed speed pattern
    set_spd(11'h7FF, 11'h001, 11'h400, 11'h000);
    finish_frame();
    finish_frame();

    // Mid-frame speed change only affects the following frame
    set_spd(11'h100, 11'h000, 11'h000, 11'h000);
    run_to(10);
    spd[0] = 11'h200;
    finish_frame();
    finish_frame();

    // One-clock kill mid-frame: current frame intact, next frame zero, then recovery
    set_spd(11'h300, 11'h300, 11'h300, 11'h300);
    run_to(100);
    kill = 1'b1;
    cycle();
    kill = 1'b0;
    finish_frame();
    finish_frame();
    finish_frame();

    // Random speeds with random mid-frame changes and kill pulses
    repeat (3) begin
      random_spd();
      do begin
        if ($urandom_range(0, 1499) == 0) random_spd();
        if ($urandom_range(0, 2999) == 0) begin
          kill = 1'b1;
          cycle();
          kill = 1'b0;
        end else begin
          cycle();
        end
      end while (k % P != 0);
    end

    // Asynchronous reset in the middle of a pulse
    random_spd();
    run_to(21);
    check("pre_reset_pwm_high", 32'(pwm), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", 32'(pwm), 32'd0);
    check("async_reset_frm_strt", 32'(frm_strt), 32'd0);
    check("async_reset_armed", 32'(armed), 32'd0);
    @(negedge clk);
    release_reset();
    finish_frame();
    random_spd();
    finish_frame();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
